ifetch_bp: RTL and testbench

Parametrised instruction-fetch unit with a direct-mapped table of 2-bit saturating branch counters. It sits between the ICache and the instruction queue. It drives the fetch PC, forwards each hit instruction with its PC and prediction, resolves JAL targets locally, and predicts conditional branches from the table. It stalls on JALR until the backend resolves it and redirects on any misprediction reported by write-back.

---
 rtl/ifetch_bp_if.sv | 38 +++
 rtl/ifetch_bp.sv | 156 +++++++++++++++
 tb/tb_ifetch_bp.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_bp_if.sv
// ifetch_bp_if: fetch-side bus of the instruction fetch unit.
//   ICache side : pc (to cache), hit, inst_in
//   IQueue side : inst_rdy, inst_out, pc_out, pred_taken, pred_pc, iqueue_full
//   Backend side: br_rdy, br_is_branch, br_is_jalr, br_pc, br_taken,
//                 br_mispredict, nex_pc
//   Global      : rdy (enable)
// master = the fetch unit, slave = its environment.
interface ifetch_bp_if;
    logic        rdy;
    logic        hit;
    logic [31:0] inst_in;
    logic [31:0] pc;
    logic        iqueue_full;
    logic        inst_rdy;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        br_rdy;
    logic        br_is_branch;
    logic        br_is_jalr;
    logic [31:0] br_pc;
    logic        br_taken;
    logic        br_mispredict;
    logic [31:0] nex_pc;

    modport master (
        input  rdy, hit, inst_in, iqueue_full,
        input  br_rdy, br_is_branch, br_is_jalr, br_pc, br_taken, br_mispredict, nex_pc,
        output pc, inst_rdy, inst_out, pc_out, pred_taken, pred_pc
    );

    modport slave (
        output rdy, hit, inst_in, iqueue_full,
        output br_rdy, br_is_branch, br_is_jalr, br_pc, br_taken, br_mispredict, nex_pc,
        input  pc, inst_rdy, inst_out, pc_out, pred_taken, pred_pc
    );
endinterface

// File: rtl/ifetch_bp.sv
// ifetch_bp: instruction fetch with a direct-mapped table of 2-bit
// saturating branch counters. Drives the fetch PC, forwards each accepted
// instruction with its PC and prediction, resolves JAL locally, predicts
// conditional branches, stalls on JALR and redirects on mispredict.
// Ports:
//   clk   - clock, all state on posedge
//   rst   - synchronous active-high reset
//   fetch - ifetch_bp_if.master (ICache, IQueue and backend signals)
module ifetch_bp #(
    parameter int          BHT_BITS  = 6,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] HALT_INST = 32'h0ff00513
) (
    input  logic         clk,
    input  logic         rst,
    ifetch_bp_if.master  fetch
);
    localparam int BHT_SIZE = 1 << BHT_BITS;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_RUN, S_WAIT_JALR, S_HALT} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_pc, w_pc_nxt;
    logic          r_inst_rdy;
    logic [31:0]   r_inst_out;
    logic [31:0]   r_pc_out;
    logic          r_pred_taken, w_pred_taken_nxt;
    logic [31:0]   r_pred_pc, w_pred_pc_nxt;
    logic          w_fetch;
    logic [1:0]    r_bht [BHT_SIZE];

    logic                w_redirect;
    logic                w_train;
    logic [BHT_BITS-1:0] w_rd_idx;
    logic [BHT_BITS-1:0] w_wr_idx;
    logic [1:0]          w_rd_ctr;
    logic [1:0]          w_wr_ctr;
    logic [6:0]          w_opcode;
    logic [31:0]         w_jimm;
    logic [31:0]         w_bimm;
    logic [31:0]         w_pc_plus4;

    assign w_redirect = fetch.br_rdy && fetch.br_mispredict;
    assign w_train    = fetch.br_rdy && fetch.br_is_branch;
    assign w_rd_idx   = r_pc[BHT_BITS+1:2];
    assign w_wr_idx   = fetch.br_pc[BHT_BITS+1:2];
    // Lookup reads the registered counter: a same-cycle update is not bypassed.
    assign w_rd_ctr   = r_bht[w_rd_idx];
    assign w_wr_ctr   = r_bht[w_wr_idx];
    assign w_opcode   = fetch.inst_in[6:0];
    assign w_jimm     = {{12{fetch.inst_in[31]}}, fetch.inst_in[19:12], fetch.inst_in[20],
                         fetch.inst_in[30:21], 1'b0};
    assign w_bimm     = {{20{fetch.inst_in[31]}}, fetch.inst_in[7], fetch.inst_in[30:25],
                         fetch.inst_in[11:8], 1'b0};
    assign w_pc_plus4 = r_pc + 32'd4;

    // Next-state / next-output logic. Redirect outranks everything, and the
    // instruction on inst_in is dropped when it coincides with a redirect.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_fetch          = 1'b0;
        w_pred_taken_nxt = 1'b0;
        w_pred_pc_nxt    = w_pc_plus4;
        if (w_redirect) begin
            w_pc_nxt    = fetch.nex_pc;
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (fetch.hit && !fetch.iqueue_full) begin
                        w_fetch = 1'b1;
                        if (fetch.inst_in == HALT_INST) begin
                            // Halt is emitted but pc parks on it.
                            w_pred_pc_nxt = r_pc;
                            w_state_nxt   = S_HALT;
                        end else begin
                            case (w_opcode)
                                OP_JAL: begin
                                    w_pc_nxt         = r_pc + w_jimm;
                                    w_pred_taken_nxt = 1'b1;
                                end
                                OP_BRANCH: begin
                                    if (w_rd_ctr[1]) begin
                                        w_pc_nxt         = r_pc + w_bimm;
                                        w_pred_taken_nxt = 1'b1;
                                    end else begin
                                        w_pc_nxt = w_pc_plus4;
                                    end
                                end
                                OP_JALR: begin
                                    // Fall-through is preloaded so a correct
                                    // resolution simply resumes.
                                    w_pc_nxt    = w_pc_plus4;
                                    w_state_nxt = S_WAIT_JALR;
                                end
                                default: w_pc_nxt = w_pc_plus4;
                            endcase
                            w_pred_pc_nxt = w_pc_nxt;
                        end
                    end
                end
                S_WAIT_JALR: begin
                    if (fetch.br_rdy && fetch.br_is_jalr) w_state_nxt = S_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_pc         <= RESET_PC;
            r_inst_rdy   <= 1'b0;
            r_inst_out   <= '0;
            r_pc_out     <= '0;
            r_pred_taken <= 1'b0;
            r_pred_pc    <= '0;
        end else if (fetch.rdy) begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inst_rdy <= w_fetch;
            if (w_fetch) begin
                r_inst_out   <= fetch.inst_in;
                r_pc_out     <= r_pc;
                r_pred_taken <= w_pred_taken_nxt;
                r_pred_pc    <= w_pred_pc_nxt;
            end
        end
    end

    // Counter training, independent of redirect and fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) r_bht[i] <= 2'b01;
        end else if (fetch.rdy && w_train) begin
            if (fetch.br_taken) begin
                if (w_wr_ctr != 2'b11) r_bht[w_wr_idx] <= w_wr_ctr + 2'd1;
            end else begin
                if (w_wr_ctr != 2'b00) r_bht[w_wr_idx] <= w_wr_ctr - 2'd1;
            end
        end
    end

    assign fetch.pc         = r_pc;
    assign fetch.inst_rdy   = r_inst_rdy;
    assign fetch.inst_out   = r_inst_out;
    assign fetch.pc_out     = r_pc_out;
    assign fetch.pred_taken = r_pred_taken;
    assign fetch.pred_pc    = r_pred_pc;
endmodule

// File: tb/tb_ifetch_bp.sv
// Bench for ifetch_bp: directed steps from the fetch scenarios followed by
// random traffic, every cycle compared with a behavioural model.
module tb_ifetch_bp;
    localparam int          BB    = 6;
    localparam int          NB    = 1 << BB;
    localparam logic [31:0] RPC   = 32'h0;
    localparam logic [31:0] HALTI = 32'h0ff00513;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] JAL1  = 32'h100000EF;  // jal x1,+0x100
    localparam logic [31:0] BEQM8 = 32'hFE000CE3;  // beq x0,x0,-8
    localparam logic [31:0] JALR0 = 32'h00008067;  // jalr x0,0(x1)
    localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_bp_if bif ();

    ifetch_bp #(.BHT_BITS(BB), .RESET_PC(RPC), .HALT_INST(HALTI)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (bif.master)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pc, m_inst, m_pcout, m_ppc;
    bit          m_vld, m_pt, m_chk_all;
    int          m_mode;
    int          m_cnt [NB];
    logic [31:0] mem [logic [31:0]];
    bit          auto_inst;

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return NOP;
    endfunction

    // Immediates as signed integers: raw field value minus 2^width when negative.
    function automatic int jimm(logic [31:0] i);
        int v;
        v = int'({i[31], i[19:12], i[20], i[30:21], 1'b0});
        if (i[31]) v = v - (1 << 21);
        return v;
    endfunction

    function automatic int bimm(logic [31:0] i);
        int v;
        v = int'({i[31], i[7], i[30:25], i[11:8], 1'b0});
        if (i[31]) v = v - (1 << 13);
        return v;
    endfunction

    task automatic model_step();
        bit pred;
        int bi;
        if (rst) begin
            m_pc = RPC; m_mode = M_RUN; m_vld = 0; m_inst = 0; m_pcout = 0;
            m_pt = 0; m_ppc = 0; m_chk_all = 1;
            foreach (m_cnt[i]) m_cnt[i] = 1;
            return;
        end
        m_chk_all = 0;
        if (!bif.rdy) return;
        pred = m_cnt[(m_pc >> 2) % NB] >= 2;
        if (bif.br_rdy && bif.br_is_branch) begin
            bi = (bif.br_pc >> 2) % NB;
            if (bif.br_taken) m_cnt[bi] = (m_cnt[bi] == 3) ? 3 : m_cnt[bi] + 1;
            else              m_cnt[bi] = (m_cnt[bi] == 0) ? 0 : m_cnt[bi] - 1;
        end
        if (bif.br_rdy && bif.br_mispredict) begin
            m_pc = bif.nex_pc; m_mode = M_RUN; m_vld = 0;
        end else if (m_mode == M_RUN && bif.hit && !bif.iqueue_full) begin
            m_vld = 1; m_inst = bif.inst_in; m_pcout = m_pc;
            if (bif.inst_in == HALTI) begin
                m_pt = 0; m_ppc = m_pc; m_mode = M_HALT;
            end else begin
                m_pt = 0; m_ppc = m_pc + 32'd4;
                case (bif.inst_in[6:0])
                    7'b1101111: begin m_pt = 1; m_ppc = m_pc + jimm(bif.inst_in); end
                    7'b1100011: if (pred) begin m_pt = 1; m_ppc = m_pc + bimm(bif.inst_in); end
                    7'b1100111: m_mode = M_WAIT;
                    default: ;
                endcase
                m_pc = m_ppc;
            end
        end else begin
            m_vld = 0;
            if (m_mode == M_WAIT && bif.br_rdy && bif.br_is_jalr) m_mode = M_RUN;
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: model advances on the same inputs, outputs compared 1ns after the edge.
    task automatic cycle();
        if (auto_inst) bif.inst_in = mem_rd(m_pc);
        model_step();
        @(posedge clk);
        #1;
        chk("pc", bif.pc, m_pc);
        chk("inst_rdy", 32'(bif.inst_rdy), 32'(m_vld));
        if (m_vld || m_chk_all) begin
            chk("inst_out", bif.inst_out, m_inst);
            chk("pc_out", bif.pc_out, m_pcout);
            chk("pred_taken", 32'(bif.pred_taken), 32'(m_pt));
            chk("pred_pc", bif.pred_pc, m_ppc);
        end
    endtask

    task automatic idle();
        bif.rdy = 1; bif.hit = 0; bif.iqueue_full = 0;
        bif.br_rdy = 0; bif.br_is_branch = 0; bif.br_is_jalr = 0;
        bif.br_taken = 0; bif.br_mispredict = 0; bif.br_pc = 0; bif.nex_pc = 0;
    endtask

    task automatic do_fetch(int n);
        bif.hit = 1;
        repeat (n) cycle();
        bif.hit = 0;
    endtask

    task automatic redirect(logic [31:0] a);
        bif.br_rdy = 1; bif.br_mispredict = 1; bif.nex_pc = a;
        cycle();
        bif.br_rdy = 0; bif.br_mispredict = 0;
    endtask

    task automatic train(logic [31:0] a, bit t);
        bif.br_rdy = 1; bif.br_is_branch = 1; bif.br_pc = a; bif.br_taken = t;
        cycle();
        bif.br_rdy = 0; bif.br_is_branch = 0;
    endtask

    task automatic jalr_resolve(bit mis, logic [31:0] a);
        bif.br_rdy = 1; bif.br_is_jalr = 1; bif.br_mispredict = mis; bif.nex_pc = a;
        cycle();
        bif.br_rdy = 0; bif.br_is_jalr = 0; bif.br_mispredict = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        idle();
        bif.inst_in = NOP;
        auto_inst = 1;
        mem[32'h10] = JAL1; mem[32'h20] = BEQM8; mem[32'h40] = JALR0; mem[32'h80] = HALTI;

        // Reset
        rst = 1; cycle(); cycle();
        chk("rst_pc", bif.pc, RPC);
        chk("rst_inst_rdy", 32'(bif.inst_rdy), 32'd0);
        rst = 0;

        // Three sequential ADDIs
        do_fetch(3);
        chk("seq_pc", bif.pc, 32'hC);
        chk("seq_pc_out", bif.pc_out, 32'h8);

        // JAL, zero bubble
        redirect(32'h10);
        do_fetch(1);
        chk("jal_pc", bif.pc, 32'h110);
        chk("jal_pred_pc", bif.pred_pc, 32'h110);
        chk("jal_taken", 32'(bif.pred_taken), 32'd1);
        do_fetch(1);
        chk("jal_nobubble", bif.pc_out, 32'h110);

        // BEQ prediction and saturation
        redirect(32'h20); do_fetch(1);
        chk("beq_nt_pc", bif.pc, 32'h24);
        train(32'h20, 1);
        redirect(32'h20); do_fetch(1);
        chk("beq_t_pc", bif.pc, 32'h18);
        repeat (4) train(32'h20, 1);
        train(32'h20, 0);
        redirect(32'h20); do_fetch(1);
        chk("beq_sat_pc", bif.pc, 32'h18);
        train(32'h20, 0);
        redirect(32'h20); do_fetch(1);
        chk("beq_dec_pc", bif.pc, 32'h24);

        // JALR stall, mispredicted then correct
        redirect(32'h40); do_fetch(4);
        chk("jalr_stall", 32'(bif.inst_rdy), 32'd0);
        jalr_resolve(1, 32'h200);
        chk("jalr_mis_pc", bif.pc, 32'h200);
        do_fetch(1);
        chk("jalr_resume", bif.pc_out, 32'h200);
        redirect(32'h40); do_fetch(2);
        jalr_resolve(0, 32'h0);
        do_fetch(1);
        chk("jalr_ok_pc_out", bif.pc_out, 32'h44);

        // iqueue_full back-pressure
        bif.iqueue_full = 1; do_fetch(3);
        chk("full_pc", bif.pc, 32'h48);
        bif.iqueue_full = 0; do_fetch(1);
        chk("full_release", bif.pc_out, 32'h48);
        cycle();

        // HALT, redirect out, reset out
        redirect(32'h80); do_fetch(4);
        chk("halt_pc", bif.pc, 32'h80);
        redirect(32'h300); do_fetch(1);
        chk("halt_exit", bif.pc_out, 32'h300);
        redirect(32'h80); do_fetch(1);
        train(32'h20, 1); train(32'h20, 1);
        rst = 1; cycle(); rst = 0;
        chk("halt_rst_pc", bif.pc, RPC);
        redirect(32'h20); do_fetch(1);
        chk("rst_ctr_pc", bif.pc, 32'h24);

        // Lookup and training on the same index in one cycle: old counter used
        redirect(32'h20);
        bif.br_rdy = 1; bif.br_is_branch = 1; bif.br_pc = 32'h20; bif.br_taken = 1;
        do_fetch(1);
        bif.br_rdy = 0; bif.br_is_branch = 0;
        chk("bypass_pc", bif.pc, 32'h24);
        redirect(32'h20); do_fetch(1);
        chk("bypass_after", bif.pc, 32'h18);

        // Redirect beats a simultaneous hit
        bif.hit = 1; redirect(32'h500); bif.hit = 0;
        chk("redir_drop", 32'(bif.inst_rdy), 32'd0);

        // rdy low holds everything, including training
        bif.rdy = 0; bif.hit = 1; train(32'h500, 1); train(32'h500, 1); bif.hit = 0; bif.rdy = 1;
        chk("rdy_hold", bif.pc, 32'h500);

        // PC wrap
        redirect(32'hFFFF_FFFC); do_fetch(1);
        chk("wrap_pc", bif.pc, 32'h0);

        // Random traffic
        auto_inst = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 39);
            if (r == 0)       bif.inst_in = HALTI;
            else if (r < 8)   bif.inst_in = {$urandom} & 32'hFFFF_FF80 | 32'h6F;
            else if (r < 20)  bif.inst_in = {$urandom} & 32'hFFFF_FF80 | 32'h63;
            else if (r < 24)  bif.inst_in = {$urandom} & 32'hFFFF_FF80 | 32'h67;
            else              bif.inst_in = {$urandom} & 32'hFFFF_FF80 | 32'h13;
            rst              = ($urandom_range(0, 299) == 0);
            bif.rdy          = ($urandom_range(0, 9) != 0);
            bif.hit          = ($urandom_range(0, 3) != 0);
            bif.iqueue_full  = ($urandom_range(0, 5) == 0);
            bif.br_rdy       = ($urandom_range(0, 2) == 0);
            bif.br_is_branch = $urandom_range(0, 1);
            bif.br_is_jalr   = $urandom_range(0, 1);
            bif.br_taken     = $urandom_range(0, 1);
            bif.br_mispredict = ($urandom_range(0, 7) == 0);
            bif.br_pc        = {$urandom_range(0, 15), 2'b00};
            bif.nex_pc       = {$urandom_range(0, 255), 2'b00};
            cycle();
        end
        rst = 0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
